// File: rtl/brpred_pkg.sv
// brpred_pkg: shared branch definitions for the decoder, comparator and
// branch predictor.
//   - funct3 encodings of the RV32I conditional branches
//   - ctr_e       : 2-bit saturating direction counter
//   - btb_entry_t : one BTB line (valid, tag, target, counter)
//   - ctr_inc/ctr_dec : saturating counter steps
package brpred_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // The tag is kept at full 32-bit width (pc >> (IDX+2)) so the struct does
  // not depend on the table size; the upper bits are always zero and fold away.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    ctr_e        ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_inc(ctr_e c);
    return (c == CTR_ST) ? CTR_ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(ctr_e c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational branch condition evaluation.
//   funct3, br_less, br_equal -> taken, legal, br_unsigned
// taken is 0 for illegal funct3 (010/011); legal flags the six branch codes.
module branch_resolve
  import brpred_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_less,
  input  logic       br_equal,
  output logic       taken,
  output logic       legal,
  output logic       br_unsigned
);

  // funct3[1] selects the unsigned compare for BLTU/BGEU.
  assign br_unsigned = funct3[1];

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (funct3)
      BR_BEQ:           taken = br_equal;
      BR_BNE:           taken = !br_equal;
      BR_BLT, BR_BLTU:  taken = br_less;
      BR_BGE, BR_BGEU:  taken = !br_less;
      default:          legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters (IF prediction)
// plus branch resolution, misprediction detection and training (EX).
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     if_pc -> pred_taken/target  fetch-side prediction (combinational)
//     ex_*                        EX-stage instruction and carried prediction
//     br_unsigned, br_less/equal  comparator handshake
//     ex_taken, mispredict, redirect_pc  resolution outputs
//   Optional: define BRPRED_STATS_EN to add stat_branches/stat_mispredicts.
module branch_predictor
  import brpred_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        br_unsigned,
  input  logic        br_less,
  input  logic        br_equal,
  output logic        ex_taken,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BRPRED_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  btb_entry_t btb [ENTRIES];

  // ---------------- fetch-side lookup ----------------
  logic [IDX-1:0] if_idx;
  logic [31:0]    if_tag;
  btb_entry_t     if_ent;

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = {{(IDX+2){1'b0}}, if_pc[31:IDX+2]};
  assign if_ent = btb[if_idx];

  assign pred_taken  = if_ent.valid && (if_ent.tag == if_tag) && if_ent.ctr[1];
  assign pred_target = pred_taken ? if_ent.target : 32'd0;

  // ---------------- EX resolution ----------------
  logic res_taken, legal;

  branch_resolve u_resolve (
    .funct3      (ex_funct3),
    .br_less     (br_less),
    .br_equal    (br_equal),
    .taken       (res_taken),
    .legal       (legal),
    .br_unsigned (br_unsigned)
  );

  logic is_br;
  assign is_br    = ex_valid && ex_is_branch && legal;
  assign ex_taken = is_br && res_taken;

  // Third term catches a taken prediction carried on something that is not a
  // legal branch: the fetched stream after it was wrong.
  assign mispredict = ex_valid && (
                        (ex_taken != ex_pred_taken) ||
                        (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)) ||
                        (ex_pred_taken && !(ex_is_branch && legal)));

  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

  // ---------------- training ----------------
  logic [IDX-1:0] ex_idx;
  logic [31:0]    ex_tag;
  logic           ex_hit;

  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = {{(IDX+2){1'b0}}, ex_pc[31:IDX+2]};
  assign ex_hit = btb[ex_idx].valid && (btb[ex_idx].tag == ex_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (ex_valid) begin
      if (ex_is_branch && legal) begin
        if (ex_hit) begin
          btb[ex_idx].ctr <= ex_taken ? ctr_inc(btb[ex_idx].ctr) : ctr_dec(btb[ex_idx].ctr);
          if (ex_taken) btb[ex_idx].target <= ex_target;
        end else if (ex_taken) begin
          // Allocation overwrites whatever aliased entry lived at this index.
          btb[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target, ctr: CTR_WT};
        end
      end else if (ex_hit) begin
        // A non-branch (or illegal encoding) matched this line: it is stale.
        btb[ex_idx].valid <= 1'b0;
      end
    end
  end

`ifdef BRPRED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (is_br)      stat_branches    <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  // Word-aligned PCs: the low two bits carry no information here.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed test-plan scenarios plus randomized traffic,
// checked every cycle against an array-based behavioural model of the BTB.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX = $clog2(ENTRIES);

  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] if_pc = 0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 0, ex_is_branch = 0;
  logic [2:0]  ex_funct3 = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic        ex_pred_taken = 0;
  logic        br_unsigned;
  logic        br_less = 0, br_equal = 0;
  logic        ex_taken, mispredict;
  logic [31:0] redirect_pc;
`ifdef BRPRED_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
  int unsigned mb = 0, mm = 0;
`endif

  int checks = 0, failures = 0;

  // model state: one slot per BTB index
  bit          mv  [ENTRIES];
  logic [31:0] mtg [ENTRIES];
  logic [31:0] mtag[ENTRIES];
  int          mc  [ENTRIES];

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .br_unsigned(br_unsigned), .br_less(br_less), .br_equal(br_equal),
    .ex_taken(ex_taken), .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BRPRED_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  function automatic bit m_legal();
    return !(ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
  endfunction

  function automatic bit m_taken();
    if (!(ex_valid && ex_is_branch)) return 0;
    case (ex_funct3)
      3'd0: return br_equal;
      3'd1: return !br_equal;
      3'd4, 3'd6: return br_less;
      3'd5, 3'd7: return !br_less;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i = m_idx(pc);
    return mv[i] && mtag[i] == m_tag(pc) && mc[i] >= 2;
  endfunction

  function automatic bit m_misp();
    bit t = m_taken();
    if (!ex_valid) return 0;
    if (t != ex_pred_taken) return 1;
    if (t && ex_pred_taken && ex_target != ex_pred_target) return 1;
    if (ex_pred_taken && !(ex_is_branch && m_legal())) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      mv[i] = 0; mc[i] = 1; mtag[i] = 0; mtg[i] = 0;
    end
`ifdef BRPRED_STATS_EN
    mb = 0; mm = 0;
`endif
  endtask

  // apply this cycle's EX effect to the model (called just after the edge)
  task automatic model_update(input bit t, input bit mp);
    int i = m_idx(ex_pc);
    bit hit = mv[i] && mtag[i] == m_tag(ex_pc);
`ifdef BRPRED_STATS_EN
    if (ex_valid && ex_is_branch && m_legal()) mb++;
    if (mp) mm++;
`endif
    if (!ex_valid) return;
    if (ex_is_branch && m_legal()) begin
      if (hit) begin
        if (t) begin mc[i] = (mc[i] < 3) ? mc[i] + 1 : 3; mtg[i] = ex_target; end
        else   mc[i] = (mc[i] > 0) ? mc[i] - 1 : 0;
      end else if (t) begin
        mv[i] = 1; mtag[i] = m_tag(ex_pc); mtg[i] = ex_target; mc[i] = 2;
      end
    end else if (hit) mv[i] = 0;
  endtask

  task automatic model_check();
    bit t = m_taken();
    bit p = m_pred(if_pc);
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, p});
    chk("pred_target", pred_target, p ? mtg[m_idx(if_pc)] : 32'd0);
    chk("ex_taken", {31'd0, ex_taken}, {31'd0, t});
    chk("mispredict", {31'd0, mispredict}, {31'd0, m_misp()});
    chk("redirect_pc", redirect_pc, t ? ex_target : ex_pc + 32'd4);
    chk("br_unsigned", {31'd0, br_unsigned}, {31'd0, ex_funct3[1]});
`ifdef BRPRED_STATS_EN
    chk("stat_branches", stat_branches, mb);
    chk("stat_mispredicts", stat_mispredicts, mm);
`endif
  endtask

  // inputs are set at the negedge; outputs are sampled 2ns later
  task automatic settle();
    #2;
    model_check();
  endtask

  task automatic tick();
    bit t = m_taken();
    bit mp = m_misp();
    @(posedge clk);
    if (rst_n) model_update(t, mp);
    @(negedge clk);
  endtask

  task automatic ex_set(input bit v, input bit br, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input bit pt, input logic [31:0] ptgt,
                        input bit lt, input bit eq);
    ex_valid = v; ex_is_branch = br; ex_funct3 = f3; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pt; ex_pred_target = ptgt; br_less = lt; br_equal = eq;
  endtask

  task automatic idle_probe(input logic [31:0] pc);
    ex_set(0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
    if_pc = pc;
    settle();
  endtask

  task automatic ex_step(input bit br, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt,
                         input bit lt, input bit eq);
    ex_set(1, br, f3, pc, tgt, pt, ptgt, lt, eq);
    settle();
  endtask

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << (IDX + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
  endfunction

  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // reset state
    idle_probe(32'h1234_5678);
    chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    chk("rst_tgt", pred_target, 32'd0);
    chk("rst_misp", {31'd0, mispredict}, 32'd0);
    tick();

    // BEQ taken, no prediction -> mispredict, allocate
    ex_step(1, 3'b000, 32'h100, 32'h200, 0, 0, 0, 1);
    chk("beq_misp", {31'd0, mispredict}, 32'd1);
    chk("beq_redir", redirect_pc, 32'h200);
    tick();
    idle_probe(32'h100);
    chk("beq_alloc_pred", {31'd0, pred_taken}, 32'd1);
    chk("beq_alloc_tgt", pred_target, 32'h200);
    tick();

    // BNE 0x40: taken x3, then not taken -> still predicts, then WNT
    for (int k = 0; k < 3; k++) begin ex_step(1, 3'b001, 32'h40, 32'h80, k > 0, 32'h80, 0, 0); tick(); end
    ex_step(1, 3'b001, 32'h40, 32'h80, 1, 32'h80, 0, 1);
    chk("bne_nt_misp", {31'd0, mispredict}, 32'd1);
    tick();
    idle_probe(32'h40);
    chk("bne_wt_pred", {31'd0, pred_taken}, 32'd1);
    tick();
    ex_step(1, 3'b001, 32'h40, 32'h80, 1, 32'h80, 0, 1);
    tick();
    idle_probe(32'h40);
    chk("bne_wnt_pred", {31'd0, pred_taken}, 32'd0);
    tick();

    // BLTU 0x80 not taken, predicted not taken
    ex_step(1, 3'b110, 32'h80, 32'h400, 0, 0, 0, 0);
    chk("bltu_misp", {31'd0, mispredict}, 32'd0);
    chk("bltu_uns", {31'd0, br_unsigned}, 32'd1);
    tick();
    idle_probe(32'h80);
    chk("bltu_noalloc", {31'd0, pred_taken}, 32'd0);
    tick();

    // aliasing: 0x100 then 0x100 + 4*ENTRIES at the same index
    ex_step(1, 3'b000, 32'h100, 32'h300, 0, 0, 0, 1); tick();
    ex_step(1, 3'b000, 32'h100 + 4 * ENTRIES, 32'h500, 0, 0, 0, 1); tick();
    idle_probe(32'h100);
    chk("alias_old", {31'd0, pred_taken}, 32'd0);
    tick();
    idle_probe(32'h100 + 4 * ENTRIES);
    chk("alias_new_tgt", pred_target, 32'h500);
    tick();

    // predicted-taken non-branch, then illegal funct3: both invalidate
    for (int k = 0; k < 2; k++) begin
      ex_step(1, 3'b000, 32'h100, 32'h300, 0, 0, 0, 1); tick();
      ex_step(k == 0 ? 1'b0 : 1'b1, k == 0 ? 3'b000 : 3'b010, 32'h100, 32'h300, 1, 32'h300, 1, 1);
      chk("nonbr_taken", {31'd0, ex_taken}, 32'd0);
      chk("nonbr_misp", {31'd0, mispredict}, 32'd1);
      chk("nonbr_redir", redirect_pc, 32'h104);
      tick();
      idle_probe(32'h100);
      chk("nonbr_inval", {31'd0, pred_taken}, 32'd0);
      tick();
    end

    // PC wrap on fall-through
    ex_step(1, 3'b000, 32'hFFFF_FFFC, 32'h10, 0, 0, 0, 0);
    chk("wrap_redir", redirect_pc, 32'h0);
    chk("wrap_misp", {31'd0, mispredict}, 32'd0);
    tick();

    // reset mid-run with a trained entry
    ex_step(1, 3'b101, 32'h100, 32'h700, 0, 0, 0, 0); tick();
    idle_probe(32'h100);
    chk("pre_rst_pred", {31'd0, pred_taken}, 32'd1);
    rst_n = 0;
    model_reset();
    settle();
    chk("mid_rst_pred", {31'd0, pred_taken}, 32'd0);
    chk("mid_rst_tgt", pred_target, 32'd0);
    tick();
    rst_n = 1;
    idle_probe(32'h100);
    tick();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc = rnd_pc();
      bit pt = ($urandom_range(0, 3) == 0) ? 1'($urandom) : m_pred(pc);
      logic [31:0] ptgt = pt ? (($urandom_range(0, 3) == 0) ? {$urandom_range(0, 3), 4'h0} : mtg[m_idx(pc)]) : 32'd0;
      ex_set($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, 3'($urandom),
             pc, {$urandom_range(0, 3), 4'h0}, pt, ptgt, 1'($urandom), 1'($urandom));
      if_pc = rnd_pc();
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
